// File: rtl/coord_stack_pkg.sv
// coord_stack shared types: stored entry layout and request-decode encoding.
// Entry is a packed {x,y} pair, 2*COORD_W bits wide.
package coord_stack_pkg;

  localparam int COORD_W_DEF = 4;

  typedef struct packed {
    logic [COORD_W_DEF-1:0] x;
    logic [COORD_W_DEF-1:0] y;
  } entry_t;

  typedef enum logic [2:0] {
    REQ_NONE    = 3'd0,
    REQ_PUSH    = 3'd1,
    REQ_POP     = 3'd2,
    REQ_PUSHPOP = 3'd3,
    REQ_PEEK    = 3'd4
  } req_e;

endpackage

// File: rtl/coord_stack_mem.sv
// coord_stack storage: DEPTH x W array, synchronous write,
// asynchronous read. Contents are never reset.
module coord_stack_mem
  import coord_stack_pkg::*;
#(
  parameter int W     = 2 * COORD_W_DEF,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/coord_stack.sv
// coord_stack: LIFO of (x,y) pairs with registered one-cycle results.
// Define COORD_STACK_PEEK_EN to add the peek request port.
module coord_stack
  import coord_stack_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int DEPTH   = 64,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
`ifdef COORD_STACK_PEEK_EN
  input  logic               peek,
`endif
  input  logic [COORD_W-1:0] xIn,
  input  logic [COORD_W-1:0] yIn,
  output logic [COORD_W-1:0] xOut,
  output logic [COORD_W-1:0] yOut,
  output logic               outValid,
  output logic               fail,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 * COORD_W;

  logic [CNT_W-1:0]   r_count;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               r_valid;
  logic               r_fail;

  logic               w_peek;
  logic               w_full;
  logic               w_empty;
  req_e               w_req;
  logic [AW-1:0]      w_top;
  logic [AW-1:0]      w_waddr;
  logic               w_we;
  logic [EW-1:0]      w_rd;
  logic [COORD_W-1:0] w_rd_x;
  logic [COORD_W-1:0] w_rd_y;

`ifdef COORD_STACK_PEEK_EN
  assign w_peek = peek;
`else
  assign w_peek = 1'b0;
`endif

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_top   = AW'(r_count - CNT_W'(1));
  assign w_rd_x  = w_rd[EW-1:COORD_W];
  assign w_rd_y  = w_rd[COORD_W-1:0];

  always_comb begin
    w_req = REQ_NONE;
    unique case (1'b1)
      (push && !pop):            w_req = REQ_PUSH;
      (!push && pop):            w_req = REQ_POP;
      (push && pop):             w_req = REQ_PUSHPOP;
      (!push && !pop && w_peek): w_req = REQ_PEEK;
      default:                   w_req = REQ_NONE;
    endcase
  end

  // push+pop replaces the top in place; a plain push appends
  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_top;
    if (!rst) begin
      if (w_req == REQ_PUSH && !w_full) begin
        w_we    = 1'b1;
        w_waddr = AW'(r_count);
      end else if (w_req == REQ_PUSHPOP && !w_empty) begin
        w_we    = 1'b1;
      end
    end
  end

  coord_stack_mem #(
    .W     (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata ({xIn, yIn}),
    .i_raddr (w_top),
    .o_rdata (w_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_x     <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_fail  <= 1'b0;
      unique case (w_req)
        REQ_PUSH: begin
          if (w_full) r_fail <= 1'b1;
          else r_count <= r_count + CNT_W'(1);
        end
        REQ_POP: begin
          if (w_empty) begin
            r_fail <= 1'b1;
          end else begin
            r_x     <= w_rd_x;
            r_y     <= w_rd_y;
            r_valid <= 1'b1;
            r_count <= r_count - CNT_W'(1);
          end
        end
        REQ_PUSHPOP: begin
          r_valid <= 1'b1;
          r_x     <= w_empty ? xIn : w_rd_x;
          r_y     <= w_empty ? yIn : w_rd_y;
        end
        REQ_PEEK: begin
          if (w_empty) begin
            r_fail <= 1'b1;
          end else begin
            r_x     <= w_rd_x;
            r_y     <= w_rd_y;
            r_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign xOut     = r_x;
  assign yOut     = r_y;
  assign outValid = r_valid;
  assign fail     = r_fail;
  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;

endmodule

// File: tb/tb_coord_stack.sv
// Bench for coord_stack: queue-based stack model checked every cycle,
// plus literal expectations from hand-worked sequences.
module tb_coord_stack;
  import coord_stack_pkg::*;

  localparam int DEPTH = 64;
`ifdef COORD_STACK_PEEK_EN
  localparam bit PEEK_ON = 1'b1;
`else
  localparam bit PEEK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic       peek = 1'b0;
  logic [3:0] xIn = '0;
  logic [3:0] yIn = '0;
  logic [3:0] xOut;
  logic [3:0] yOut;
  logic       outValid;
  logic       fail;
  logic       full;
  logic       empty;
  logic [6:0] count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  coord_stack dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
`ifdef COORD_STACK_PEEK_EN
    .peek     (peek),
`endif
    .xIn      (xIn),
    .yIn      (yIn),
    .xOut     (xOut),
    .yOut     (yOut),
    .outValid (outValid),
    .fail     (fail),
    .full     (full),
    .empty    (empty),
    .count    (count)
  );

  function automatic void chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
  endfunction

  // Model: the stack is a queue, back = top.
  entry_t q[$];
  int     m_x, m_y, m_v, m_f;
  bit     m_ok = 1'b0;

  always @(posedge clk) begin
    entry_t e;
    m_x = 0; m_y = 0; m_v = 0; m_f = 0;
    e.x = xIn;
    e.y = yIn;
    if (rst) begin
      q.delete();
    end else if (push && pop) begin
      m_v = 1;
      if (q.size() == 0) begin
        m_x = xIn; m_y = yIn;
      end else begin
        m_x = q[q.size()-1].x;
        m_y = q[q.size()-1].y;
        q[q.size()-1] = e;
      end
    end else if (push) begin
      if (q.size() == DEPTH) m_f = 1;
      else q.push_back(e);
    end else if (pop) begin
      if (q.size() == 0) begin
        m_f = 1;
      end else begin
        e = q.pop_back();
        m_x = e.x; m_y = e.y; m_v = 1;
      end
    end else if (PEEK_ON && peek) begin
      if (q.size() == 0) begin
        m_f = 1;
      end else begin
        m_x = q[q.size()-1].x;
        m_y = q[q.size()-1].y;
        m_v = 1;
      end
    end
    m_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_xOut", int'(xOut), m_x);
      chk("m_yOut", int'(yOut), m_y);
      chk("m_outValid", int'(outValid), m_v);
      chk("m_fail", int'(fail), m_f);
      chk("m_count", int'(count), q.size());
      chk("m_full", int'(full), int'(q.size() == DEPTH));
      chk("m_empty", int'(empty), int'(q.size() == 0));
    end
  end

  task automatic step(bit r, bit pu, bit po, bit pk, int x, int y);
    rst = r; push = pu; pop = po; peek = pk;
    xIn = 4'(x); yIn = 4'(y);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_valid", int'(outValid), 0);

    step(0, 1, 0, 0, 3, 5);
    step(0, 1, 0, 0, 7, 2);
    chk("push2_count", int'(count), 2);
    step(0, 0, 1, 0, 0, 0);
    chk("pop1_xy", int'({xOut, yOut}), 8'h72);
    chk("pop1_valid", int'(outValid), 1);
    chk("pop1_count", int'(count), 1);
    step(0, 0, 1, 0, 0, 0);
    chk("pop2_xy", int'({xOut, yOut}), 8'h35);
    chk("pop2_count", int'(count), 0);
    chk("pop2_empty", int'(empty), 1);

    step(0, 0, 1, 0, 0, 0);
    chk("uflow_fail", int'(fail), 1);
    chk("uflow_valid", int'(outValid), 0);
    chk("uflow_xy", int'({xOut, yOut}), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("uflow_pulse", int'(fail), 0);

    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0, i % 16, 15 - i % 16);
    chk("fill_full", int'(full), 1);
    chk("fill_count", int'(count), 64);
    step(0, 1, 0, 0, 1, 1);
    chk("oflow_fail", int'(fail), 1);
    chk("oflow_count", int'(count), 64);
    step(0, 1, 1, 0, 9, 9);
    chk("pp_full_xy", int'({xOut, yOut}), 8'hF0);
    chk("pp_full_valid", int'(outValid), 1);
    chk("pp_full_fail", int'(fail), 0);
    chk("pp_full_count", int'(count), 64);
    step(0, 0, 1, 0, 0, 0);
    chk("pp_top_xy", int'({xOut, yOut}), 8'h99);
    step(0, 0, 1, 0, 0, 0);
    chk("pop62_xy", int'({xOut, yOut}), 8'hE1);

    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 4, 6);
    chk("byp_xy", int'({xOut, yOut}), 8'h46);
    chk("byp_valid", int'(outValid), 1);
    chk("byp_count", int'(count), 0);
    chk("byp_fail", int'(fail), 0);

    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, i, i + 1);
    chk("p5_count", int'(count), 5);
    step(1, 1, 0, 0, 8, 8);
    chk("rstp_count", int'(count), 0);
    chk("rstp_out", int'({xOut, yOut, outValid, fail}), 0);
    step(0, 0, 1, 0, 0, 0);
    chk("rstp_pop_fail", int'(fail), 1);

`ifdef COORD_STACK_PEEK_EN
    step(0, 1, 0, 0, 1, 2);
    step(0, 0, 0, 1, 0, 0);
    chk("peek1_xy", int'({xOut, yOut, outValid}), 9'h025);
    step(0, 0, 0, 1, 0, 0);
    chk("peek2_xy", int'({xOut, yOut, outValid}), 9'h025);
    chk("peek_count", int'(count), 1);
    step(0, 0, 1, 1, 0, 0);
    chk("peek_pop_xy", int'({xOut, yOut}), 8'h12);
    step(0, 0, 0, 1, 0, 0);
    chk("peek_empty_fail", int'(fail), 1);
    chk("peek_empty_valid", int'(outValid), 0);
`endif

    step(0, 0, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
